// File: rtl/db_ram_1p_fifo_ctrl_pkg.sv
// Shared constants and word type for the deblocking single-port RAM FIFO.
// Also used by the RAM wrappers, so keep it free of controller-only details.
package db_ram_pkg;

  localparam int DATA_WD = 17;
  localparam int ADDR_WD = 8;
  localparam int DEPTH   = 1 << ADDR_WD;

  typedef logic [DATA_WD-1:0] word_t;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } gnt_e;

endpackage

// File: rtl/db_ram_1p_fifo_ctrl_if.sv
// Valid/ready write and read streams of the deblocking RAM FIFO.
// master: producer/consumer side; slave: the FIFO controller.
interface db_ram_1p_fifo_ctrl_if;
  import db_ram_pkg::*;

  logic  wr_val_i;
  word_t wr_dat_i;
  logic  wr_rdy_o;
  logic  rd_val_o;
  word_t rd_dat_o;
  logic  rd_rdy_i;

  modport master (
    output wr_val_i, wr_dat_i, rd_rdy_i,
    input  wr_rdy_o, rd_val_o, rd_dat_o
  );

  modport slave (
    input  wr_val_i, wr_dat_i, rd_rdy_i,
    output wr_rdy_o, rd_val_o, rd_dat_o
  );

endinterface

// File: rtl/db_out_buf2.sv
// 2-entry in-order output queue absorbing the RAM read latency.
// Ports: clk, rst, clr, push/din (tail write), pop, cnt (0..2), head.
module db_out_buf2
  import db_ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       push,
  input  word_t      din,
  input  logic       pop,
  output logic [1:0] cnt,
  output word_t      head
);

  word_t tail;
  logic  pop_ok;

  assign pop_ok = pop && (cnt != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else if (clr) begin
      cnt  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      unique case ({push, pop_ok})
        2'b10: begin
          if (cnt == 2'd0) head <= din;
          else             tail <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          // count unchanged; new word goes wherever the vacated slot is
          if (cnt == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/db_ram_1p_fifo_ctrl.sv
// FIFO controller multiplexing a write and a read stream onto one SRAM port.
// Ports: clk, rst, clr_i, bus (stream if), cnt/full/empty, ram_* SRAM port.
module db_ram_1p_fifo_ctrl
  import db_ram_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  db_ram_1p_fifo_ctrl_if.slave bus,
  output logic [ADDR_WD:0]    cnt_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                ram_cen_o,
  output logic                ram_oen_o,
  output logic                ram_wen_o,
  output logic [ADDR_WD-1:0]  ram_addr_o,
  output word_t               ram_dat_o,
  input  word_t               ram_dat_i
);

  logic [ADDR_WD-1:0] wptr;
  logic [ADDR_WD-1:0] rptr;
  logic [ADDR_WD:0]   mem_cnt;
  logic               inflight;
  gnt_e               last_gnt;
  logic [1:0]         out_cnt;

  logic       blk;
  logic       pop;
  logic [2:0] occ;
  logic       wr_cand;
  logic       rd_cand;
  logic       wr_gnt;
  logic       rd_gnt;

  // reset is also gated here so the RAM port idles while rst is held
  assign blk = rst || clr_i;
  assign pop = bus.rd_val_o && bus.rd_rdy_i;

  // output slots that will be taken once any in-flight read lands
  assign occ = {1'b0, out_cnt} + {2'b0, inflight} - {2'b0, pop};

  assign full_o  = (mem_cnt == (ADDR_WD+1)'(DEPTH));
  assign wr_cand = bus.wr_val_i && !full_o && !blk;
  assign rd_cand = (mem_cnt != '0) && (occ < 3'd2) && !blk;

  assign bus.wr_rdy_o = !full_o && (!rd_cand || last_gnt == GNT_RD);

  assign wr_gnt = wr_cand && (!rd_cand || last_gnt == GNT_RD);
  assign rd_gnt = rd_cand && (!wr_cand || last_gnt == GNT_WR);

  assign ram_cen_o  = !(wr_gnt || rd_gnt);
  assign ram_wen_o  = !wr_gnt;
  assign ram_oen_o  = 1'b0;
  assign ram_addr_o = wr_gnt ? wptr : rptr;
  assign ram_dat_o  = bus.wr_dat_i;

  assign cnt_o   = mem_cnt;
  assign empty_o = (mem_cnt == '0) && !inflight && (out_cnt == 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
      last_gnt <= GNT_WR;
    end else if (clr_i) begin
      wptr     <= '0;
      rptr     <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
      last_gnt <= GNT_WR;
    end else begin
      inflight <= rd_gnt;
      if (wr_gnt) wptr <= wptr + 1'b1;
      if (rd_gnt) rptr <= rptr + 1'b1;
      unique case (1'b1)
        wr_gnt: begin
          mem_cnt  <= mem_cnt + 1'b1;
          last_gnt <= GNT_WR;
        end
        rd_gnt: begin
          mem_cnt  <= mem_cnt - 1'b1;
          last_gnt <= GNT_RD;
        end
        default: ;
      endcase
    end
  end

  db_out_buf2 u_out_buf (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_i),
    .push (inflight),
    .din  (ram_dat_i),
    .pop  (pop),
    .cnt  (out_cnt),
    .head (bus.rd_dat_o)
  );

  assign bus.rd_val_o = (out_cnt != 2'd0);

endmodule

// File: tb/tb_db_ram_1p_fifo_ctrl.sv
// Scoreboard bench for db_ram_1p_fifo_ctrl with a behavioural RAM model.
// Accepted writes queue expected words; a monitor checks pops and addresses.
module tb_db_ram_1p_fifo_ctrl;
  import db_ram_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               clr_i;
  logic [ADDR_WD:0]   cnt_o;
  logic               full_o;
  logic               empty_o;
  logic               ram_cen_o;
  logic               ram_oen_o;
  logic               ram_wen_o;
  logic [ADDR_WD-1:0] ram_addr_o;
  word_t              ram_dat_o;
  word_t              ram_dat_i;

  db_ram_1p_fifo_ctrl_if bus ();

  db_ram_1p_fifo_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr_i),
    .bus        (bus),
    .cnt_o      (cnt_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .ram_cen_o  (ram_cen_o),
    .ram_oen_o  (ram_oen_o),
    .ram_wen_o  (ram_wen_o),
    .ram_addr_o (ram_addr_o),
    .ram_dat_o  (ram_dat_o),
    .ram_dat_i  (ram_dat_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int wen_cnt = 0;
  word_t expq[$];
  word_t mem [DEPTH];
  logic [ADDR_WD-1:0] wa = '0;
  logic [ADDR_WD-1:0] ra = '0;
  bit saw_wrap = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // single-port SRAM: data out one cycle after a read, noise otherwise
  always @(posedge clk) begin
    if (!ram_cen_o && !ram_wen_o) mem[ram_addr_o] <= ram_dat_o;
    if (!ram_cen_o && ram_wen_o) ram_dat_i <= mem[ram_addr_o];
    else ram_dat_i <= word_t'($urandom);
  end

  // expected data: every accepted write, flushed by reset/clear
  always @(negedge clk) begin
    if (rst || clr_i) expq.delete();
    else if (bus.wr_val_i && bus.wr_rdy_o) begin
      expq.push_back(bus.wr_dat_i);
      acc_cnt++;
    end
  end

  // monitor: output order and RAM address sequence (nth access at n mod DEPTH)
  always @(negedge clk) begin : mon
    word_t e;
    if (rst || clr_i) begin
      wa = '0;
      ra = '0;
    end else begin
      if (bus.rd_val_o && bus.rd_rdy_i) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_extra got %0h want none", bus.rd_dat_o);
        end else begin
          e = expq.pop_front();
          chk("rd_dat", bus.rd_dat_o, e);
        end
      end
      if (!ram_cen_o && !ram_wen_o) begin
        chk("wr_addr", ram_addr_o, wa);
        if (wa == '1) saw_wrap = 1'b1;
        wa = wa + 1'b1;
        wen_cnt++;
      end
      if (!ram_cen_o && ram_wen_o) begin
        chk("rd_addr", ram_addr_o, ra);
        ra = ra + 1'b1;
      end
    end
  end

  task automatic chk_reset_vals(string tag);
    chk({tag, "_wr_rdy"}, bus.wr_rdy_o, 1);
    chk({tag, "_rd_val"}, bus.rd_val_o, 0);
    chk({tag, "_rd_dat"}, bus.rd_dat_o, 0);
    chk({tag, "_cnt"}, cnt_o, 0);
    chk({tag, "_full"}, full_o, 0);
    chk({tag, "_empty"}, empty_o, 1);
    chk({tag, "_cen"}, ram_cen_o, 1);
    chk({tag, "_oen"}, ram_oen_o, 0);
    chk({tag, "_wen"}, ram_wen_o, 1);
    chk({tag, "_addr"}, ram_addr_o, 0);
  endtask

  task automatic drain(string tag);
    int t = 0;
    bus.wr_val_i = 1'b0;
    bus.rd_rdy_i = 1'b1;
    while (!empty_o && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    chk({tag, "_empty"}, empty_o, 1);
    chk({tag, "_q_left"}, expq.size(), 0);
  endtask

  initial begin
    int a0;
    int w0;
    int n;
    int t;
    int sent;
    word_t d;

    rst = 1'b1;
    clr_i = 1'b0;
    bus.wr_val_i = 1'b0;
    bus.wr_dat_i = '0;
    bus.rd_rdy_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // single word: write in N, rd_val_o in N+3
    bus.rd_rdy_i = 1'b1;
    w0 = wen_cnt;
    bus.wr_val_i = 1'b1;
    bus.wr_dat_i = 17'h1ABCD;
    @(negedge clk);
    chk("sw_wr_rdy", bus.wr_rdy_o, 1);
    chk("sw_wen", ram_wen_o, 0);
    chk("sw_addr", ram_addr_o, 0);
    @(posedge clk); #1;
    bus.wr_val_i = 1'b0;
    chk("sw_val_n1", bus.rd_val_o, 0);
    @(posedge clk); #1;
    chk("sw_val_n2", bus.rd_val_o, 0);
    @(posedge clk); #1;
    chk("sw_val_n3", bus.rd_val_o, 1);
    chk("sw_dat_n3", bus.rd_dat_o, 17'h1ABCD);
    @(posedge clk); #1;
    chk("sw_empty", empty_o, 1);
    chk("sw_val_n4", bus.rd_val_o, 0);
    chk("sw_wen_cnt", wen_cnt - w0, 1);

    // fill: no consumer, 300 cycles of offered writes
    bus.rd_rdy_i = 1'b0;
    a0 = acc_cnt;
    for (int i = 0; i < 300; i++) begin
      bus.wr_val_i = 1'b1;
      bus.wr_dat_i = word_t'($urandom);
      @(posedge clk); #1;
    end
    chk("fill_accepts", acc_cnt - a0, 258);
    chk("fill_wr_rdy", bus.wr_rdy_o, 0);
    chk("fill_full", full_o, 1);
    chk("fill_cnt", cnt_o, 256);
    chk("fill_rd_val", bus.rd_val_o, 1);

    // full RAM, read granted in N -> full_o low in N+1
    bus.wr_val_i = 1'b0;
    bus.rd_rdy_i = 1'b1;
    @(negedge clk);
    chk("fd_rd_gnt", {ram_cen_o, ram_wen_o}, 2'b01);
    chk("fd_full_n", full_o, 1);
    @(posedge clk); #1;
    chk("fd_full_n1", full_o, 0);
    drain("fill");

    // contention: both streams always on -> W,R,W,R...
    d = 17'h0;
    bus.rd_rdy_i = 1'b1;
    bus.wr_val_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.wr_dat_i = d;
      @(negedge clk);
      chk("cont_gnt", {ram_cen_o, ram_wen_o},
          (i % 2 == 0) ? 2'b00 : 2'b01);
      if (bus.wr_rdy_o) d = d + 1'b1;
      @(posedge clk); #1;
    end
    drain("cont");

    // wrap: 600 incrementing words, random valid and ready
    d = 17'h100;
    sent = 0;
    t = 0;
    bus.wr_dat_i = d;
    bus.wr_val_i = ($urandom_range(3) != 0);
    bus.rd_rdy_i = $urandom_range(1) != 0;
    while (sent < 600 && t < 10000) begin
      @(negedge clk);
      if (bus.wr_val_i && bus.wr_rdy_o) begin
        sent++;
        d = d + 1'b1;
      end
      @(posedge clk); #1;
      t++;
      bus.wr_dat_i = d;
      bus.wr_val_i = (sent < 600) && ($urandom_range(3) != 0);
      bus.rd_rdy_i = $urandom_range(1) != 0;
    end
    chk("wrap_sent", sent, 600);
    drain("wrap");
    chk("wrap_seen", saw_wrap, 1);

    // clear in the cycle after a read grant
    bus.rd_rdy_i = 1'b0;
    bus.wr_val_i = 1'b1;
    n = 0;
    t = 0;
    bus.wr_dat_i = 17'h00A00;
    while (n < 4 && t < 100) begin
      @(negedge clk);
      if (bus.wr_rdy_o) n++;
      @(posedge clk); #1;
      t++;
      bus.wr_dat_i = 17'h00A00 + word_t'(n);
    end
    chk("clr_setup_n", n, 4);
    bus.wr_val_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.rd_rdy_i = 1'b1;
    @(negedge clk);
    chk("clr_rd_gnt", {ram_cen_o, ram_wen_o}, 2'b01);
    @(posedge clk); #1;
    clr_i = 1'b1;
    @(negedge clk);
    chk("clr_cen", ram_cen_o, 1);
    @(posedge clk); #1;
    clr_i = 1'b0;
    chk("clr_rd_val", bus.rd_val_o, 0);
    chk("clr_cnt", cnt_o, 0);
    chk("clr_empty", empty_o, 1);
    @(posedge clk); #1;
    chk("clr_no_capture", bus.rd_val_o, 0);
    bus.wr_val_i = 1'b1;
    bus.wr_dat_i = 17'h0BEEF;
    @(negedge clk);
    chk("clr_wr_addr", ram_addr_o, 0);
    @(posedge clk); #1;
    bus.wr_val_i = 1'b0;
    t = 0;
    while (!bus.rd_val_o && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("clr_next_val", bus.rd_val_o, 1);
    chk("clr_next_dat", bus.rd_dat_o, 17'h0BEEF);
    drain("clr");

    // asynchronous reset in the middle of a stream
    bus.rd_rdy_i = 1'b0;
    bus.wr_val_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.wr_dat_i = word_t'($urandom);
      @(posedge clk); #1;
    end
    chk("mid_pre_val", bus.rd_val_o, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("mid");
    @(posedge clk); #1;
    rst = 1'b0;
    bus.wr_dat_i = 17'h15555;
    @(negedge clk);
    chk("mid_wr_wen", ram_wen_o, 0);
    chk("mid_wr_addr", ram_addr_o, 0);
    @(posedge clk); #1;
    drain("mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/db_ram_1p_fifo_ctrl.md
# db_ram_1p_fifo_ctrl

FIFO controller that drives a 17x256 single-port deblocking SRAM: it accepts a valid/ready write stream, drains a valid/ready read stream in order, and time-multiplexes both onto the one RAM port. It sits between the deblocking filter's boundary-info producer and consumer, with the single-port RAM instance outside the block. A 2-entry output buffer absorbs the RAM's one-cycle read latency.

## Interface
- DATA_WD, 17, word width
- ADDR_WD, 8, RAM address width
- DEPTH, 256, RAM entries (2**ADDR_WD)

- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- clr_i  in  1  synchronous clear, active-high
- wr_val_i  in  1  write word valid
- wr_dat_i  in  DATA_WD  write word
- wr_rdy_o  out  1  write accepted when wr_val_i && wr_rdy_o
- rd_val_o  out  1  read word valid
- rd_dat_o  out  DATA_WD  read word
- rd_rdy_i  in  1  consumer ready; pop when rd_val_o && rd_rdy_i
- cnt_o  out  ADDR_WD+1  words resident in RAM (0..256)
- full_o  out  1  cnt_o == DEPTH
- empty_o  out  1  RAM, in-flight read and output buffer all empty
- ram_cen_o  out  1  RAM chip enable, active-low
- ram_oen_o  out  1  RAM output enable, active-low, tied 0
- ram_wen_o  out  1  RAM write enable, active-low
- ram_addr_o  out  ADDR_WD  RAM address
- ram_dat_o  out  DATA_WD  RAM write data, equal to wr_dat_i
- ram_dat_i  in  DATA_WD  RAM read data, valid the cycle after the read access

## Operation
- State: wptr and rptr (ADDR_WD, natural wrap 255->0), mem_cnt (cnt_o), inflight flag, out_cnt (0..2), last_gnt (0 = write, 1 = read).
- Write candidate: wr_val_i && !full_o. wr_rdy_o = !full_o && (!rd_cand || last_gnt). wr_rdy_o does not depend on wr_val_i.
- Read candidate (rd_cand): mem_cnt != 0 && (out_cnt + inflight - pop) < 2.
- Arbitration, at most one RAM access per cycle. If only one candidate exists, it is granted. If both exist, grant the opposite of last_gnt. last_gnt updates only on a granted access.
- Write grant: cen=0, wen=0, addr=wptr; wptr+1, mem_cnt+1.
- Read grant: cen=0, wen=1, addr=rptr; rptr+1, mem_cnt-1, inflight=1 for the next cycle.
- While inflight, ram_dat_i is captured at the end of that cycle into the output buffer tail.
- Output buffer: 2-entry in-order queue. rd_val_o = out_cnt != 0. rd_dat_o = head. A same-cycle pop and capture is legal.
- Idle cycle: cen=1, wen=1, addr=rptr.
- clr_i has priority over all else: no RAM access that cycle (cen=1). Pointers, counts, inflight and out buffer are zeroed, and any in-flight read data is discarded. last_gnt goes to 0.
- Async rst has the same effect as clr_i, applied immediately.

## Timing
- Reset values: wr_rdy_o=1, rd_val_o=0, rd_dat_o=0, cnt_o=0, full_o=0, empty_o=1, ram_cen_o=1, ram_oen_o=0, ram_wen_o=1, ram_addr_o=0.
- Write accepted in cycle N, with no contention and rd_rdy_i=1:
  - RAM write in N
  - read issued N+1
  - captured end of N+2
  - rd_val_o high in N+3
- Sustained read-only drain: 1 word per cycle when rd_rdy_i is held high.
- Simultaneous streams: writes and reads alternate, 1/2 throughput each.
- Capacity: 256 in RAM plus 2 in the output buffer = 258 words.
- A full RAM with a read granted in cycle N: full_o drops in N+1.

## Structure
- Package db_ram_pkg: DATA_WD, ADDR_WD, DEPTH constants and a word typedef, shared with the RAM wrappers.
- One sub-module, db_out_buf2: the 2-entry valid/ready output queue with push, pop, count and head data.
- Arbitration, pointers and counters live in the top module.

## Test plan
- Reset: assert rst mid-stream -> all outputs take their reset values immediately, and the next accepted write lands at addr 0.
- Single word: write 0x1ABCD at cycle N with rd_rdy_i=1 -> exactly one wen=0 access at addr 0, rd_val_o in N+3 with 0x1ABCD, empty_o=1 after the pop.
- Fill: rd_rdy_i=0, wr_val_i held for 300 cycles -> 258 accepts, then wr_rdy_o=0, full_o=1, cnt_o=256, rd_val_o=1.
- Contention: both streams continuous -> grants alternate W,R starting with W, and the output sequence equals the input sequence.
- Wrap: stream 600 incrementing words with random rd_rdy_i -> in-order, lossless output, and addresses wrap 255->0.
- Clear: pulse clr_i in the cycle after a read grant -> no capture, rd_val_o=0 and cnt_o=0 next cycle, and the next output is the first word written after the clear.
